// File: rtl/d8m_pkg.sv
// ---------------------------------------------------------------------------
// d8m_pkg
// Types and constants shared by the D8M pattern transmitter and the
// camera-path bench monitor.
//   PIX_W    : pixel data width on the D8M parallel bus
//   state_e  : timing FSM states of the transmitter
//   pat_e    : pattern_sel encodings
// ---------------------------------------------------------------------------
package d8m_pkg;

  localparam int PIX_W = 10;

  localparam logic [PIX_W-1:0] PIX_HI = '1;
  localparam logic [PIX_W-1:0] PIX_LO = '0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    ACTIVE = 3'd2,
    BLANK  = 3'd3,
    TAIL   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PAT_RAMP  = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_COUNT = 2'd3
  } pat_e;

endpackage

// File: rtl/d8m_pattern_tx_if.sv
// ---------------------------------------------------------------------------
// d8m_pattern_tx_if
// D8M parallel pixel bus (D/FVAL/LVAL).
//   pix_d : pixel data, meaningful only while lval=1
//   fval  : frame valid
//   lval  : line valid, only high while fval=1
// master = pattern transmitter, slave = camera receiver / monitor.
// ---------------------------------------------------------------------------
interface d8m_pattern_tx_if;
  import d8m_pkg::*;

  logic [PIX_W-1:0] pix_d;
  logic             fval;
  logic             lval;

  modport master (output pix_d, fval, lval);
  modport slave  (input  pix_d, fval, lval);

endinterface

// File: rtl/d8m_pattern_gen.sv
// ---------------------------------------------------------------------------
// d8m_pattern_gen
// Combinational pixel value for the current active pixel. The parent
// registers the result.
//   pat_sel : latched pattern for this frame
//   x       : active pixel index, low PIX_W bits
//   y_odd   : y[0], Bayer row parity
//   y_blk   : y[3], checker row block
//   bar     : colour bar index 0..7
//   fc      : frame count latched at frame start
//   pix     : pixel value
// ---------------------------------------------------------------------------
module d8m_pattern_gen
  import d8m_pkg::*;
(
  input  pat_e             pat_sel,
  input  logic [PIX_W-1:0] x,
  input  logic             y_odd,
  input  logic             y_blk,
  input  logic [2:0]       bar,
  input  logic [PIX_W-1:0] fc,
  output logic [PIX_W-1:0] pix
);

  logic bar_bit;

  // RGGB site select: R on even/even, B on odd/odd, G elsewhere.
  always_comb begin
    case ({y_odd, x[0]})
      2'b00:   bar_bit = bar[2];
      2'b11:   bar_bit = bar[0];
      default: bar_bit = bar[1];
    endcase
  end

  always_comb begin
    pix = PIX_LO;
    case (pat_sel)
      PAT_RAMP:  pix = x;
      PAT_BARS:  pix = bar_bit ? PIX_HI : PIX_LO;
      PAT_CHECK: pix = (x[3] ^ y_blk) ? PIX_HI : PIX_LO;
      PAT_COUNT: pix = fc;
      default:   pix = PIX_LO;
    endcase
  end

endmodule

// File: rtl/d8m_pattern_tx.sv
// ---------------------------------------------------------------------------
// d8m_pattern_tx
// Synthetic frame source for the D8M parallel pixel bus. Produces whole
// frames (no truncation) in the format consumed by the camera receiver.
//   clk         : pixel clock, rising edge
//   reset_n     : async assert, active-low
//   enable      : stream frames while high; a frame in flight always completes
//   pattern_sel : 0 ramp, 1 Bayer bars, 2 checker, 3 frame count
//   bus         : D8M bus master (pix_d, fval, lval)
//   frame_done  : one-cycle pulse on the cycle fval falls
//   frame_cnt   : completed frames since reset, wraps
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | fval=0, gap counter runs; start when enabled and gap served
// LEAD   | fval=1, lval=0 for V_LEAD cycles before the first line
// ACTIVE | fval=1, lval=1 for H_ACTIVE pixels of line y
// BLANK  | fval=1, lval=0 for H_BLANK cycles between lines
// TAIL   | fval=1, lval=0 for V_TAIL cycles after the last line
// ---------------------------------------------------------------------------
module d8m_pattern_tx
  import d8m_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 160,
  parameter int V_LEAD   = 16,
  parameter int V_TAIL   = 16,
  parameter int V_GAP    = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [1:0]              pattern_sel,
  d8m_pattern_tx_if.master        bus,
  output logic                    frame_done,
  output logic [15:0]             frame_cnt
);

  if (H_ACTIVE < 8 || (H_ACTIVE % 8) != 0 || H_ACTIVE > 65535) begin : g_bad_h_active
    $error("d8m_pattern_tx: H_ACTIVE must be a multiple of 8 in 8..65535");
  end
  if (V_ACTIVE < 1 || V_ACTIVE > 65535) begin : g_bad_v_active
    $error("d8m_pattern_tx: V_ACTIVE must be in 1..65535");
  end
  if (H_BLANK < 1 || H_BLANK > 65535) begin : g_bad_h_blank
    $error("d8m_pattern_tx: H_BLANK must be in 1..65535");
  end
  if (V_LEAD < 1 || V_LEAD > 65535) begin : g_bad_v_lead
    $error("d8m_pattern_tx: V_LEAD must be in 1..65535");
  end
  if (V_TAIL < 1 || V_TAIL > 65535) begin : g_bad_v_tail
    $error("d8m_pattern_tx: V_TAIL must be in 1..65535");
  end
  if (V_GAP < 1 || V_GAP > 65535) begin : g_bad_v_gap
    $error("d8m_pattern_tx: V_GAP must be in 1..65535");
  end

  localparam logic [15:0] X_LAST   = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST   = 16'(V_ACTIVE - 1);
  localparam logic [15:0] LEAD_LD  = 16'(V_LEAD - 1);
  localparam logic [15:0] BLANK_LD = 16'(H_BLANK - 1);
  localparam logic [15:0] TAIL_LD  = 16'(V_TAIL - 1);
  localparam logic [15:0] BAR_LD   = 16'(H_ACTIVE / 8 - 1);
  localparam logic [15:0] GAP_MAX  = 16'(V_GAP);

  state_e           state_q, state_d;
  logic [15:0]      tmr_q, tmr_d;
  logic [15:0]      x_q, x_d;
  logic [15:0]      y_q, y_d;
  logic [2:0]       bar_q, bar_d;
  logic [15:0]      bar_cnt_q, bar_cnt_d;
  logic [15:0]      gap_q, gap_d;
  logic [15:0]      gap_inc;
  pat_e             pat_q, pat_d;
  logic [PIX_W-1:0] fc_q, fc_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             fval_q, fval_d;
  logic             lval_q, lval_d;
  logic             done_q, done_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;
  logic [PIX_W-1:0] gen_pix;

  // ---- state register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      bar_q       <= '0;
      bar_cnt_q   <= '0;
      gap_q       <= GAP_MAX;  // saturated: first frame may start at once
      pat_q       <= PAT_RAMP;
      fc_q        <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      bar_q       <= bar_d;
      bar_cnt_q   <= bar_cnt_d;
      gap_q       <= gap_d;
      pat_q       <= pat_d;
      fc_q        <= fc_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // gap_inc counts the current IDLE cycle, so a start decision on it yields
  // exactly V_GAP fval-low cycles between frames.
  assign gap_inc = (gap_q >= GAP_MAX) ? GAP_MAX : gap_q + 16'd1;

  // ---- next-state and counter logic ----
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    x_d         = x_q;
    y_d         = y_q;
    bar_d       = bar_q;
    bar_cnt_d   = bar_cnt_q;
    gap_d       = gap_q;
    pat_d       = pat_q;
    fc_d        = fc_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        gap_d = gap_inc;
        if (enable && gap_inc >= GAP_MAX) begin
          state_d = LEAD;
          tmr_d   = LEAD_LD;
          pat_d   = pat_e'(pattern_sel);
          fc_d    = frame_cnt_q[PIX_W-1:0];
        end
      end
      LEAD: begin
        if (tmr_q == '0) begin
          state_d   = ACTIVE;
          x_d       = '0;
          y_d       = '0;
          bar_d     = '0;
          bar_cnt_d = BAR_LD;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      ACTIVE: begin
        if (x_q == X_LAST) begin
          if (y_q == Y_LAST) begin
            state_d = TAIL;
            tmr_d   = TAIL_LD;
          end else begin
            state_d = BLANK;
            tmr_d   = BLANK_LD;
            y_d     = y_q + 16'd1;
          end
        end else begin
          x_d = x_q + 16'd1;
          // bar index advances every H_ACTIVE/8 pixels
          if (bar_cnt_q == '0) begin
            bar_d     = bar_q + 3'd1;
            bar_cnt_d = BAR_LD;
          end else begin
            bar_cnt_d = bar_cnt_q - 16'd1;
          end
        end
      end
      BLANK: begin
        if (tmr_q == '0) begin
          state_d   = ACTIVE;
          x_d       = '0;
          bar_d     = '0;
          bar_cnt_d = BAR_LD;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      TAIL: begin
        if (tmr_q == '0) begin
          state_d     = IDLE;
          gap_d       = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  d8m_pattern_gen u_gen (
    .pat_sel (pat_d),
    .x       (x_d[PIX_W-1:0]),
    .y_odd   (y_d[0]),
    .y_blk   (y_d[3]),
    .bar     (bar_d),
    .fc      (fc_d),
    .pix     (gen_pix)
  );

  // ---- output decode ----
  // Decoded from the next state so the registered bus lines up with state_q.
  always_comb begin
    fval_d  = (state_d != IDLE);
    lval_d  = (state_d == ACTIVE);
    pixel_d = lval_d ? gen_pix : PIX_LO;
    done_d  = (state_q == TAIL) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      done_q  <= 1'b0;
      pixel_q <= '0;
    end else begin
      fval_q  <= fval_d;
      lval_q  <= lval_d;
      done_q  <= done_d;
      pixel_q <= pixel_d;
    end
  end

  assign bus.pix_d  = pixel_q;
  assign bus.fval   = fval_q;
  assign bus.lval   = lval_q;
  assign frame_done = done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_d8m_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_d8m_pattern_tx
// Self-checking bench for d8m_pattern_tx with small frame parameters.
// Frames are captured from the bus at the falling clock edge and compared
// against a pixel model derived from the pattern rules.
// ---------------------------------------------------------------------------
module tb_d8m_pattern_tx;

  localparam int H_A = 16;
  localparam int V_A = 4;
  localparam int HB  = 3;
  localparam int VL  = 2;
  localparam int VT  = 2;
  localparam int VG  = 5;
  localparam int FVAL_LEN = VL + V_A * H_A + (V_A - 1) * HB + VT;  // 77

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        frame_done;
  logic [15:0] frame_cnt;

  d8m_pattern_tx_if bus ();

  d8m_pattern_tx #(
    .H_ACTIVE (H_A),
    .V_ACTIVE (V_A),
    .H_BLANK  (HB),
    .V_LEAD   (VL),
    .V_TAIL   (VT),
    .V_GAP    (VG)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .bus         (bus),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_frames;
  int          pix_cap [V_A][H_A];

  // Bayer RGGB bars with 2-pixel bars, first two lines.
  int bars_l0 [H_A] = '{0, 0, 0, 0, 0, 1023, 0, 1023, 1023, 0, 1023, 0, 1023, 1023, 1023, 1023};
  int bars_l1 [H_A] = '{0, 0, 0, 1023, 1023, 0, 1023, 1023, 0, 0, 0, 1023, 1023, 0, 1023, 1023};

  typedef struct {
    logic [1:0] sel;
    int         mid_at;
    logic [1:0] mid_sel;
    int         drop_at;
    int         en_at;
    int         exp_gap;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int exp_pix(input int sel, input int x, input int y, input int fc);
    int b;
    int bit_v;
    case (sel)
      0: return x % 1024;
      1: begin
        b = x / (H_A / 8);
        if (y % 2 == 0 && x % 2 == 0)      bit_v = (b >> 2) & 1;
        else if (y % 2 == 1 && x % 2 == 1) bit_v = b & 1;
        else                               bit_v = (b >> 1) & 1;
        return (bit_v != 0) ? 1023 : 0;
      end
      2: return (((x / 8) % 2) != ((y / 8) % 2)) ? 1023 : 0;
      default: return fc;
    endcase
  endfunction

  // Called on a falling edge while fval=0. Waits out the gap (counting
  // fval-low cycles from here), captures one frame and checks it.
  task automatic run_frame(input logic [1:0] sel, input int mid_at, input logic [1:0] mid_sel,
                           input int drop_at, input int en_at, input int exp_gap);
    int   guard, cyc, lines, xi, low_run, lead;
    int   blank_bad, len_bad, zero_bad, done_bad, gap_done, px_bad, fc;
    logic lval_prev;
    pattern_sel = sel;
    guard    = 0;
    gap_done = 0;
    while (!bus.fval && guard < 300) begin
      if (guard == en_at) enable = 1'b1;
      if (guard > 0 && frame_done) gap_done++;
      @(negedge clk);
      guard++;
    end
    check("gap_len", guard, exp_gap);
    check("done_in_gap", gap_done, 0);
    if (!bus.fval) return;

    fc = int'(exp_frames[9:0]);
    for (int yy = 0; yy < V_A; yy++)
      for (int xx = 0; xx < H_A; xx++) pix_cap[yy][xx] = -1;
    cyc = 0; lines = 0; xi = 0; low_run = 0; lead = -1;
    blank_bad = 0; len_bad = 0; zero_bad = 0; done_bad = 0;
    lval_prev = 1'b0;
    while (bus.fval && cyc < 300) begin
      if (cyc == mid_at)  pattern_sel = mid_sel;
      if (cyc == drop_at) enable = 1'b0;
      if (frame_done) done_bad++;
      if (bus.lval) begin
        if (!lval_prev) begin
          if (lines == 0) lead = low_run;
          else if (low_run != HB) blank_bad++;
          xi = 0;
        end
        if (lines < V_A && xi < H_A) pix_cap[lines][xi] = int'(bus.pix_d);
        xi++;
        low_run = 0;
      end else begin
        if (bus.pix_d != '0) zero_bad++;
        if (lval_prev) begin
          if (xi != H_A) len_bad++;
          lines++;
        end
        low_run++;
      end
      lval_prev = bus.lval;
      @(negedge clk);
      cyc++;
    end
    check("fval_len", cyc, FVAL_LEN);
    check("lead_len", lead, VL);
    check("lines", lines, V_A);
    check("line_len_bad", len_bad, 0);
    check("blank_bad", blank_bad, 0);
    check("tail_len", low_run, VT);
    check("pix_nonzero_lval_low", zero_bad, 0);
    check("done_during_fval", done_bad, 0);
    check("frame_done_at_fall", int'(frame_done), 1);
    exp_frames = exp_frames + 16'd1;
    check("frame_cnt", int'(frame_cnt), int'(exp_frames));
    px_bad = 0;
    for (int yy = 0; yy < V_A; yy++)
      for (int xx = 0; xx < H_A; xx++)
        if (pix_cap[yy][xx] != exp_pix(int'(sel), xx, yy, fc)) px_bad++;
    check("pixels", px_bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int bad0, bad1;

    //           sel   mid_at mid_sel drop_at en_at exp_gap
    tbl[0] = '{2'd0, -1, 2'd0, -1,  0,  1};   // first frame after reset
    tbl[1] = '{2'd1, -1, 2'd0, -1, -1, VG};
    tbl[2] = '{2'd2, 30, 2'd0, -1, -1, VG};   // toggle mid-frame
    tbl[3] = '{2'd0, 50, 2'd3, -1, -1, VG};   // toggled value now applies
    tbl[4] = '{2'd3, -1, 2'd0, 45, -1, VG};   // enable drops during line 2
    tbl[5] = '{2'd2, -1, 2'd0, -1, 20, 21};   // stays idle until re-enabled
    tbl[6] = '{2'd1, -1, 2'd0, 45, -1, VG};
    tbl[7] = '{2'd0, -1, 2'd0, -1,  2, VG};   // re-enable 2 cycles after fall

    reset_n     = 1'b0;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    exp_frames  = 16'd0;
    #2;
    check("rst_fval", int'(bus.fval), 0);
    check("rst_lval", int'(bus.lval), 0);
    check("rst_pix", int'(bus.pix_d), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_disabled_fval", int'(bus.fval), 0);

    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i].sel, tbl[i].mid_at, tbl[i].mid_sel, tbl[i].drop_at, tbl[i].en_at,
                tbl[i].exp_gap);
      if (tbl[i].sel == 2'd1) begin
        bad0 = 0;
        bad1 = 0;
        for (int xx = 0; xx < H_A; xx++) begin
          if (pix_cap[0][xx] != bars_l0[xx]) bad0++;
          if (pix_cap[1][xx] != bars_l1[xx]) bad1++;
        end
        check("bars_line0", bad0, 0);
        check("bars_line1", bad1, 0);
      end
    end

    for (int k = 0; k < 6; k++) begin
      run_frame(2'($urandom_range(0, 3)), int'($urandom_range(0, FVAL_LEN - 1)),
                2'($urandom_range(0, 3)), -1, -1, VG);
    end

    // Async reset in the middle of a ramp line.
    pattern_sel = 2'd0;
    guard = 0;
    while (!bus.lval && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("lval_seen", int'(bus.lval), 1);
    repeat (3) @(negedge clk);
    check("pre_reset_pix", int'(bus.pix_d), 3);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_fval", int'(bus.fval), 0);
    check("async_rst_lval", int'(bus.lval), 0);
    check("async_rst_pix", int'(bus.pix_d), 0);
    check("async_rst_frame_cnt", int'(frame_cnt), 0);
    repeat (2) @(negedge clk);
    reset_n    = 1'b1;
    exp_frames = 16'd0;
    run_frame(2'd2, -1, 2'd0, -1, -1, 1);

    // Frame counter wrap; one gap cycle is spent holding the force.
    force dut.frame_cnt_q = 16'hFFFE;
    exp_frames = 16'hFFFE;
    @(negedge clk);
    release dut.frame_cnt_q;
    run_frame(2'd3, -1, 2'd0, -1, -1, VG - 1);
    run_frame(2'd3, -1, 2'd0, -1, -1, VG);
    check("frame_cnt_wrap", int'(frame_cnt), 0);
    run_frame(2'd3, -1, 2'd0, -1, -1, VG);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
